// File: rtl/pa_lsu_sram_arb_pkg.sv
// Shared widths, FSM encoding and SRAM idle strobe levels for the LSU SRAM controller.
package pa_lsu_sram_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Strobes are active-low; idle means deselected, no write.
    localparam logic SRAM_CEN_IDLE  = 1'b1;
    localparam logic SRAM_GWEN_IDLE = 1'b1;

endpackage

// File: rtl/pa_lsu_sram_rr_arb.sv
// Two-input round-robin arbiter; the pointer always favours the last loser.
module pa_lsu_sram_rr_arb (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       en,
    input  logic [1:0] req_vld,
    output logic [1:0] gnt_c
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // Grant selection and pointer update.
    always_comb begin
        gnt_c    = 2'b00;
        rr_ptr_d = rr_ptr_q;
        if (en) begin
            case (req_vld)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = rr_ptr_q ? 2'b10 : 2'b01;
                default: gnt_c = 2'b00;
            endcase
        end
        if (gnt_c != 2'b00) begin
            rr_ptr_d = gnt_c[0];
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/pa_lsu_sram_arb.sv
// LSU SRAM port controller: zero-fill sweep after reset, then round-robin sharing
// of the single port between two requesters with one-cycle read return.
module pa_lsu_sram_arb
    import pa_lsu_sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    output logic                  req0_gnt,
    output logic                  req0_rvld,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  req1_gnt,
    output logic                  req1_rvld,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = {ADDR_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rvld0_q, rvld0_d;
    logic                  rvld1_q, rvld1_d;
    logic [1:0]            gnt_c;

    pa_lsu_sram_rr_arb u_rr_arb (
        .clk     (forever_cpuclk),
        .rst_b   (cpurst_b),
        .en      (init_done_q),
        .req_vld ({req1_vld, req0_vld}),
        .gnt_c   (gnt_c)
    );

    // Grants are forced off while reset is held, even if init_done is still set.
    assign req0_gnt   = gnt_c[0] & cpurst_b;
    assign req1_gnt   = gnt_c[1] & cpurst_b;
    assign init_done  = init_done_q;
    assign req0_rvld  = rvld0_q;
    assign req1_rvld  = rvld1_q;
    assign req0_rdata = rvld0_q ? sram_q : '0;
    assign req1_rdata = rvld1_q ? sram_q : '0;

    // Next-state, init sweep and SRAM strobe generation.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rvld0_d     = 1'b0;
        rvld1_d     = 1'b0;
        sram_cen    = SRAM_CEN_IDLE;
        sram_gwen   = SRAM_GWEN_IDLE;
        sram_wen    = '1;
        sram_a      = '0;
        sram_d      = '0;
        if (cpurst_b) begin
            case (state_q)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = init_cnt_q;
                    sram_d    = INIT_DATA;
                    if (init_cnt_q == INIT_LAST) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end else begin
                        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (req0_gnt) begin
                        sram_cen  = 1'b0;
                        sram_a    = req0_addr;
                        if (req0_wr) begin
                            sram_gwen = 1'b0;
                            sram_wen  = ~req0_wmask;
                            sram_d    = req0_wdata;
                        end else begin
                            rvld0_d = 1'b1;
                        end
                    end else if (req1_gnt) begin
                        sram_cen  = 1'b0;
                        sram_a    = req1_addr;
                        if (req1_wr) begin
                            sram_gwen = 1'b0;
                            sram_wen  = ~req1_wmask;
                            sram_d    = req1_wdata;
                        end else begin
                            rvld1_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // State, sweep counter and read-valid registers.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rvld0_q     <= 1'b0;
            rvld1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rvld0_q     <= rvld0_d;
            rvld1_q     <= rvld1_d;
        end
    end

endmodule

// File: tb/tb_pa_lsu_sram_arb.sv
// Directed bench for pa_lsu_sram_arb with a behavioural 1024x4 SRAM model.
module tb_pa_lsu_sram_arb;

    logic       clk;
    logic       cpurst_b;
    logic       req0_vld, req0_wr, req0_gnt, req0_rvld;
    logic [9:0] req0_addr;
    logic [3:0] req0_wdata, req0_wmask, req0_rdata;
    logic       req1_vld, req1_wr, req1_gnt, req1_rvld;
    logic [9:0] req1_addr;
    logic [3:0] req1_wdata, req1_wmask, req1_rdata;
    logic       init_done, sram_cen, sram_gwen;
    logic [3:0] sram_wen, sram_d, sram_q;
    logic [9:0] sram_a;

    logic [3:0] mem [1024];
    int         errors;
    int         checks;

    pa_lsu_sram_arb dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .req0_vld       (req0_vld),
        .req0_wr        (req0_wr),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_wmask     (req0_wmask),
        .req0_gnt       (req0_gnt),
        .req0_rvld      (req0_rvld),
        .req0_rdata     (req0_rdata),
        .req1_vld       (req1_vld),
        .req1_wr        (req1_wr),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_wmask     (req1_wmask),
        .req1_gnt       (req1_gnt),
        .req1_rvld      (req1_rvld),
        .req1_rdata     (req1_rdata),
        .init_done      (init_done),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: bit-masked write, registered read.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic vld, input logic wr, input logic [9:0] a,
                        input logic [3:0] wd, input logic [3:0] wm);
        req0_vld = vld; req0_wr = wr; req0_addr = a; req0_wdata = wd; req0_wmask = wm;
    endtask

    task automatic set1(input logic vld, input logic wr, input logic [9:0] a,
                        input logic [3:0] wd, input logic [3:0] wm);
        req1_vld = vld; req1_wr = wr; req1_addr = a; req1_wdata = wd; req1_wmask = wm;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        sram_q   = 4'h0;
        cpurst_b = 1'b0;
        set0(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        set1(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);

        // Reset held: idle strobes, no grants, cleared registers.
        tick(); tick(); tick();
        #1;
        chk("rst_idle", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            32'({1'b1, 1'b1, 4'hF, 10'h0, 4'h0}));
        chk("rst_regs", 32'({init_done, req0_rvld, req1_rvld, req0_gnt, req1_gnt}), 32'h0);

        // Init sweep; requester 1 starts asking for 0x3FF near the end and must be held off.
        cpurst_b = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            if (i == 1000) set1(1'b1, 1'b0, 10'h3FF, 4'h0, 4'h0);
            #1;
            chk("init_a", 32'(sram_a), 32'(i));
            chk("init_strobes", 32'({sram_cen, sram_gwen, sram_wen, sram_d, init_done}), 32'h0);
            if (i >= 1000) chk("init_gnt_held", 32'({req0_gnt, req1_gnt}), 32'h0);
            tick();
        end

        // First RUN cycle: init_done up and the held request is granted.
        #1;
        chk("run_init_done", 32'(init_done), 32'h1);
        chk("run_held_gnt", 32'({req1_gnt, req0_gnt}), 32'h2);
        chk("run_held_rd", 32'({sram_cen, sram_gwen, sram_wen, sram_a}), 32'({1'b0, 1'b1, 4'hF, 10'h3FF}));
        tick();
        set1(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("rd3ff_rvld", 32'({req1_rvld, req0_rvld}), 32'h2);
        chk("rd3ff_data", 32'(req1_rdata), 32'h0);

        // Full write then read-back of 0x005.
        tick();
        set0(1'b1, 1'b1, 10'h005, 4'hA, 4'hF);
        #1;
        chk("wr5_gnt", 32'(req0_gnt), 32'h1);
        chk("wr5_bus", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            32'({1'b0, 1'b0, 4'h0, 10'h005, 4'hA}));
        tick();
        set0(1'b1, 1'b0, 10'h005, 4'h0, 4'h0);
        #1;
        chk("rd5_gnt", 32'(req0_gnt), 32'h1);
        chk("rd5_bus", 32'({sram_gwen, sram_wen, sram_d}), 32'({1'b1, 4'hF, 4'h0}));
        tick();
        set0(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("rd5_rvld", 32'({req1_rvld, req0_rvld}), 32'h1);
        chk("rd5_data", 32'(req0_rdata), 32'hA);
        chk("idle_bus", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            32'({1'b1, 1'b1, 4'hF, 10'h0, 4'h0}));

        // Masked write: bits 1:0 take 01 from 0x5, bits 3:2 keep 10 from 0xA -> 0x9.
        tick();
        set0(1'b1, 1'b1, 10'h005, 4'h5, 4'h3);
        #1;
        chk("mwr_wen", 32'(sram_wen), 32'hC);
        tick();
        set0(1'b1, 1'b0, 10'h005, 4'h0, 4'h0);
        #1;
        chk("mrd_gnt", 32'(req0_gnt), 32'h1);
        tick();
        set0(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("mrd_data", 32'({req0_rvld, req0_rdata}), 32'h19);

        // Requester 1 writes 0x6 at 0x010; pointer now favours requester 0.
        tick();
        set1(1'b1, 1'b1, 10'h010, 4'h6, 4'hF);
        #1;
        chk("r1wr_gnt", 32'({req1_gnt, req0_gnt}), 32'h2);

        // Continuous dual reads: grants alternate starting with requester 0.
        for (int k = 0; k < 6; k++) begin
            tick();
            set0(1'b1, 1'b0, 10'h005, 4'h0, 4'h0);
            set1(1'b1, 1'b0, 10'h010, 4'h0, 4'h0);
            #1;
            chk("dual_gnt", 32'({req1_gnt, req0_gnt}), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                chk("dual_rvld", 32'({req1_rvld, req0_rvld}), (k % 2 == 1) ? 32'h1 : 32'h2);
                chk("dual_rdata", 32'({req1_rdata, req0_rdata}), (k % 2 == 1) ? 32'h09 : 32'h60);
            end
        end
        tick();
        set0(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        set1(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        #1;
        chk("dual_last", 32'({req1_rvld, req0_rvld, req1_rdata, req0_rdata}), 32'h260);

        // Reset in RUN right after a read grant cancels the pending return and restarts init.
        tick();
        set0(1'b1, 1'b0, 10'h005, 4'h0, 4'h0);
        #1;
        chk("pre_rst_gnt", 32'(req0_gnt), 32'h1);
        tick();
        set0(1'b0, 1'b0, 10'h0, 4'h0, 4'h0);
        cpurst_b = 1'b0;
        #1;
        chk("rst_run_idle", 32'({sram_cen, req0_gnt, req1_gnt}), 32'h4);
        tick();
        cpurst_b = 1'b1;
        #1;
        chk("rst_run_regs", 32'({req0_rvld, req1_rvld, init_done}), 32'h0);
        chk("reinit_a0", 32'({sram_cen, sram_a}), 32'h0);
        tick();
        #1;
        chk("reinit_a1", 32'({sram_cen, sram_a}), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pa_lsu_sram_arb.md
Name: pa_lsu_sram_arb

Overview:
- Controller for the LSU's 1024x4 single-port SRAM wrapper.
- After reset it zero-fills every entry, then shares the single port between two requesters using 2-way round-robin arbitration.
- Drives the SRAM's active-low strobes (CEN, GWEN, per-bit WEN) and returns read data one cycle after the grant.
- Sits between the LSU requesters (req0, req1) and the SRAM macro wrapper.

Parameters:
ADDR_WIDTH, 10, SRAM address width (depth = 2**ADDR_WIDTH)
DATA_WIDTH, 4, SRAM data width; also the per-bit write-mask width
INIT_DATA, 0, value written to every entry during init

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  reset, synchronous, active-low
req0_vld  input  1  requester 0 access request
req0_wr  input  1  1=write, 0=read
req0_addr  input  ADDR_WIDTH  address
req0_wdata  input  DATA_WIDTH  write data
req0_wmask  input  DATA_WIDTH  per-bit write enable, 1=write that bit
req0_gnt  output  1  access accepted this cycle
req0_rvld  output  1  read data valid (one cycle after a read grant)
req0_rdata  output  DATA_WIDTH  read data
req1_*  same set as req0_*, for requester 1
init_done  output  1  init sweep complete; grants allowed
sram_cen  output  1  chip enable, active-low
sram_gwen  output  1  global write enable, active-low
sram_wen  output  DATA_WIDTH  bit write enables, active-low
sram_a  output  ADDR_WIDTH  SRAM address
sram_d  output  DATA_WIDTH  SRAM write data
sram_q  input  DATA_WIDTH  SRAM read data, valid the cycle after a read access

Behaviour:
- Reset and clock: one clock (forever_cpuclk). Reset is synchronous and active-low: cpurst_b is sampled at the rising edge.
- Idle SRAM outputs: cen=1, gwen=1, wen=all-1, a=0, d=0.
- While cpurst_b==0:
  - SRAM outputs are forced to idle; gnt=0.
  - At the edge, registers go to: state=INIT, init_cnt=0, init_done=0, rr_ptr=0, rvld=0 (both).
- FSM states: INIT, RUN. No other states.
- INIT:
  - Each cycle drives cen=0, gwen=0, wen=all-0, a=init_cnt, d=INIT_DATA; init_cnt increments.
  - At init_cnt==2**ADDR_WIDTH-1 the write is issued and state becomes RUN.
  - INIT therefore lasts exactly 1024 cycles. init_done=1 from the first RUN cycle.
  - gnt=0 for both requesters throughout INIT; requests are held off, not dropped.
- RUN arbitration (combinational, same cycle):
  - Only one req_vld set: that requester is granted.
  - Both set: the requester selected by rr_ptr is granted.
  - After any grant, rr_ptr <= index of the non-granted requester, so there is no starvation under continuous dual requests.
  - Nothing requesting: SRAM outputs idle, rr_ptr holds.
- Granted access (combinational from the winner):
  - cen=0, a=req_addr.
  - Write: gwen=0, wen=~req_wmask, d=req_wdata. A wmask of 0 still issues an access; no bits change.
  - Read: gwen=1, wen=all-1, d=0.
- Read return:
  - reqN_rvld is registered high for exactly one cycle, the cycle after reqN's read grant.
  - reqN_rdata = reqN_rvld ? sram_q : 0.
- Throughput: one access per cycle. A read grant followed by a grant to the other requester in the next cycle is legal; rvld and the new access overlap.
- Ordering: accesses complete in grant order. A read granted in the cycle after a write to the same address returns the new data.
- Reset mid-operation:
  - During INIT: the sweep restarts from 0.
  - During RUN: a pending rvld is cancelled and a full INIT is re-run.
- Width rules: init_cnt is ADDR_WIDTH bits; the terminal compare is against all-ones, with no wrap-around beyond that.

Decomposition:
- Shared package: ADDR_WIDTH/DATA_WIDTH defaults, the FSM state encoding (INIT=1'b0, RUN=1'b1), and the SRAM idle constants.
- Sub-module pa_lsu_sram_rr_arb: 2-input round-robin arbiter. It holds rr_ptr and produces the one-hot grant from {req1_vld, req0_vld} and init_done.

Test Plan:
- Release reset, no requests -> 1024 writes at a=0..1023 with wen=4'h0, d=0; init_done rises cycle 1025; then read 10'h3FF -> rdata=4'h0.
- RUN: req0 write a=10'h005, wdata=4'hA, wmask=4'hF; next cycle req0 read 10'h005 -> gnt each cycle, req0_rvld one cycle later, rdata=4'hA.
- Masked write: 10'h005 holds 4'hA; write wdata=4'h5, wmask=4'h3 (sram_wen=4'hC) -> later read returns 4'h9.
- Both requesters hold vld for 6 cycles after init -> grants alternate req0, req1, req0, ...; each read's rvld goes only to its owner.
- Request asserted during INIT -> gnt=0 until init_done; granted in the first RUN cycle with no loss.
- cpurst_b low for 1 cycle in RUN, in the cycle after a read grant -> req_rvld=0 after the edge, init_done=0, INIT restarts at a=0.
